// File: rtl/wb2apb_pkg.sv
// Shared types and helpers for the Wishbone-to-APB multi-slave bridge.
package wb2apb_pkg;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Outcome of the most recent transfer, kept for debug visibility.
  typedef logic [1:0] resp_t;
  localparam resp_t RC_OK      = 2'd0;
  localparam resp_t RC_SLVERR  = 2'd1;
  localparam resp_t RC_DECERR  = 2'd2;
  localparam resp_t RC_TIMEOUT = 2'd3;

  // Width of the slave-index field; a single slave still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the wait-state counter; kept at one bit when the timeout is off.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path selector: picks prdata/pready/pslverr of the addressed slave.
module apb_slave_mux
  import wb2apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic [NUM_SLAVES*32-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]    pready,
  input  logic [NUM_SLAVES-1:0]    pslverr,
  output logic [31:0]              sel_prdata,
  output logic                     sel_pready,
  output logic                     sel_pslverr
);

  // AND-OR select; an out-of-range index yields all zeros.
  always_comb begin
    sel_prdata  = 32'h0000_0000;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_prdata  = sel_prdata  | (prdata[32*k +: 32] & {32{idx == IDX_W'(k)}});
      sel_pready  = sel_pready  | (pready[k]  & (idx == IDX_W'(k)));
      sel_pslverr = sel_pslverr | (pslverr[k] & (idx == IDX_W'(k)));
    end
  end

endmodule

// File: rtl/wb2apb_multi_bridge.sv
// Wishbone classic slave to multi-slave APB bridge with wait states,
// error reporting, decode-miss handling and an ACCESS-phase timeout.
module wb2apb_multi_bridge
  import wb2apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_LSB   = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [31:0]              wbs_dat_o,
  output logic [31:0]              apb_paddr,
  output logic [NUM_SLAVES-1:0]    apb_psel,
  output logic                     apb_penable,
  output logic                     apb_pwrite,
  output logic [31:0]              apb_pwdata,
  output logic [3:0]               apb_pstrb,
  input  logic [NUM_SLAVES*32-1:0] apb_prdata,
  input  logic [NUM_SLAVES-1:0]    apb_pready,
  input  logic [NUM_SLAVES-1:0]    apb_pslverr
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [CNT_W-1:0]    cnt_r;
  resp_t               status_r;
  logic                abort_r;
  logic                miss_r;
  logic [31:0]         paddr_r;
  logic [31:0]         pwdata_r;
  logic                pwrite_r;
  logic [3:0]          pstrb_r;
  logic [NUM_SLAVES-1:0] psel_r;
  logic                penable_r;
  logic                ack_r;
  logic                err_r;
  logic [31:0]         dat_r;

  logic [IDX_W-1:0]    idx_s;
  logic                miss_s;
  logic                req_s;
  logic                quiet_s;
  logic                expire_s;
  logic [31:0]         sel_prdata_s;
  logic                sel_pready_s;
  logic                sel_pslverr_s;

  assign idx_s    = wbs_adr_i[SLV_ADDR_LSB +: IDX_W];
  assign miss_s   = ({1'b0, idx_s} >= (IDX_W+1)'(NUM_SLAVES));
  assign req_s    = wbs_stb_i & wbs_cyc_i;
  // Once the master has dropped cyc, the transfer finishes silently.
  assign quiet_s  = abort_r | ~wbs_cyc_i;
  assign expire_s = TIMEOUT_EN && (cnt_r == CNT_LAST);

  apb_slave_mux #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_mux (
    .idx         (idx_r),
    .prdata      (apb_prdata),
    .pready      (apb_pready),
    .pslverr     (apb_pslverr),
    .sel_prdata  (sel_prdata_s),
    .sel_pready  (sel_pready_s),
    .sel_pslverr (sel_pslverr_s)
  );

  // Bridge FSM with timeout counter and all registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      cnt_r     <= '0;
      status_r  <= RC_OK;
      abort_r   <= 1'b0;
      miss_r    <= 1'b0;
      paddr_r   <= 32'h0000_0000;
      pwdata_r  <= 32'h0000_0000;
      pwrite_r  <= 1'b0;
      pstrb_r   <= 4'h0;
      psel_r    <= '0;
      penable_r <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      dat_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          dat_r <= 32'h0000_0000;
          if (req_s) begin
            paddr_r  <= wbs_adr_i;
            pwdata_r <= wbs_dat_i;
            pwrite_r <= wbs_we_i;
            pstrb_r  <= wbs_sel_i & {4{wbs_we_i}};
            idx_r    <= idx_s;
            abort_r  <= 1'b0;
            if (miss_s) begin
              // No APB slave exists here: answer with an error, no bus cycle.
              status_r <= RC_DECERR;
              miss_r   <= 1'b1;
              state_r  <= RESP;
            end else begin
              miss_r   <= 1'b0;
              psel_r   <= NUM_SLAVES'(1'b1) << idx_s;
              state_r  <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_r <= 1'b1;
          cnt_r     <= '0;
          abort_r   <= abort_r | ~wbs_cyc_i;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          abort_r <= abort_r | ~wbs_cyc_i;
          if (sel_pready_s) begin
            // A ready slave takes priority over a simultaneous timeout.
            psel_r    <= '0;
            penable_r <= 1'b0;
            status_r  <= sel_pslverr_s ? RC_SLVERR : RC_OK;
            ack_r     <= ~quiet_s & ~sel_pslverr_s;
            err_r     <= ~quiet_s & sel_pslverr_s;
            dat_r     <= (~quiet_s & ~sel_pslverr_s & ~pwrite_r) ? sel_prdata_s : 32'h0000_0000;
            state_r   <= RESP;
          end else if (expire_s) begin
            psel_r    <= '0;
            penable_r <= 1'b0;
            status_r  <= RC_TIMEOUT;
            ack_r     <= 1'b0;
            err_r     <= ~quiet_s;
            dat_r     <= 32'h0000_0000;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (miss_r) begin
            // Decode miss spends one cycle here before raising err.
            miss_r <= 1'b0;
            err_r  <= wbs_cyc_i & (status_r != RC_OK);
            ack_r  <= 1'b0;
            dat_r  <= 32'h0000_0000;
          end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= 32'h0000_0000;
            state_r <= IDLE;
          end
        end
        default: begin
          psel_r    <= '0;
          penable_r <= 1'b0;
          ack_r     <= 1'b0;
          err_r     <= 1'b0;
          dat_r     <= 32'h0000_0000;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o   = ack_r;
  assign wbs_err_o   = err_r;
  assign wbs_dat_o   = dat_r;
  assign apb_paddr   = paddr_r;
  assign apb_psel    = psel_r;
  assign apb_penable = penable_r;
  assign apb_pwrite  = pwrite_r;
  assign apb_pwdata  = pwdata_r;
  assign apb_pstrb   = pstrb_r;

endmodule

// File: tb/tb_wb2apb_multi_bridge.sv
// Self-checking bench for wb2apb_multi_bridge: directed table, random
// transfers against a reference model, plus abort and reset sequences.
module tb_wb2apb_multi_bridge;

  localparam int NS = 3;
  localparam int T  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack, err;
  logic [31:0] dat_o;
  logic [31:0] paddr;
  logic [NS-1:0] psel;
  logic        penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [NS*32-1:0] prdata;
  logic [NS-1:0] pready, pslverr;

  int checks = 0;
  int errors = 0;

  int          slv_wait [NS];
  logic        slv_err  [NS];
  logic [31:0] slv_data [NS];
  int          acc_cnt = 0;
  logic [31:0] noise = 32'h0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          wt;
    logic        serr;
    logic [31:0] rdata;
    logic        e_ack;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_dat;
    logic [2:0]  e_psel;
    logic [3:0]  e_pstrb;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  wb2apb_multi_bridge #(
    .NUM_SLAVES     (NS),
    .SLV_ADDR_LSB   (12),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (wdat),
    .wbs_adr_i   (adr),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err),
    .wbs_dat_o   (dat_o),
    .apb_paddr   (paddr),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_pstrb   (pstrb),
    .apb_prdata  (prdata),
    .apb_pready  (pready),
    .apb_pslverr (pslverr)
  );

  // Count completed ACCESS cycles of the current transfer.
  always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  // Garbage for unselected slaves, which the bridge must ignore.
  always @(negedge clk) noise <= $urandom;

  // Slave models: selected slave follows its programmed wait/err/data.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      pready[k]  = (psel[k] && penable) ? (acc_cnt >= slv_wait[k]) : noise[k];
      pslverr[k] = psel[k] ? slv_err[k] : noise[k+4];
      prdata[32*k +: 32] = psel[k] ? slv_data[k] : ~noise;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one request from the bridge's rules.
  function automatic vec_t model(input vec_t v);
    int idx;
    idx       = int'(v.adr[13:12]);
    v.e_ack   = 1'b0;
    v.e_err   = 1'b0;
    v.e_dat   = 32'h0;
    v.e_psel  = 3'b000;
    v.e_pstrb = v.we ? v.sel : 4'h0;
    if (idx >= NS) begin
      v.e_err = 1'b1;
      v.e_lat = 2;
    end else begin
      v.e_psel = 3'(1 << idx);
      if (v.wt >= T) begin
        v.e_err = 1'b1;
        v.e_lat = T + 2;
      end else begin
        v.e_lat = 3 + v.wt;
        v.e_ack = !v.serr;
        v.e_err = v.serr;
        v.e_dat = (!v.we && !v.serr) ? v.rdata : 32'h0;
      end
    end
    return v;
  endfunction

  // Run one Wishbone request and compare everything observed to v.
  task automatic apply(input vec_t v, input string tag);
    int          idx;
    int          n;
    logic        done, seen, any_psel;
    logic [2:0]  psel_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    logic [3:0]  pstrb_seen;
    logic        pwrite_seen;
    logic        r_ack, r_err, r_pen;
    logic [31:0] r_dat;
    logic [2:0]  r_psel;
    idx = int'(v.adr[13:12]);
    if (idx < NS) begin
      slv_wait[idx] = v.wt;
      slv_err[idx]  = v.serr;
      slv_data[idx] = v.rdata;
    end
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = v.we; adr = v.adr; wdat = v.wdata; sel = v.sel;
    n = 0; done = 1'b0; seen = 1'b0; any_psel = 1'b0;
    psel_seen = 3'b0; paddr_seen = 32'h0; pwdata_seen = 32'h0; pstrb_seen = 4'h0; pwrite_seen = 1'b0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (psel != 3'b000) begin
        any_psel = 1'b1;
        if (!seen) begin
          seen = 1'b1;
          psel_seen = psel; paddr_seen = paddr; pwdata_seen = pwdata;
          pstrb_seen = pstrb; pwrite_seen = pwrite;
        end
      end
      if (ack || err) done = 1'b1;
    end
    r_ack = ack; r_err = err; r_dat = dat_o; r_psel = psel; r_pen = penable;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk({tag, " responded"}, 32'(done), 32'd1);
    chk({tag, " ack"}, 32'(r_ack), 32'(v.e_ack));
    chk({tag, " err"}, 32'(r_err), 32'(v.e_err));
    chk({tag, " latency"}, 32'(n), 32'(v.e_lat));
    chk({tag, " dat_o"}, r_dat, v.e_dat);
    chk({tag, " psel/penable at resp"}, 32'({r_psel, r_pen}), 32'd0);
    if (v.e_psel != 3'b000) begin
      chk({tag, " psel"}, 32'(psel_seen), 32'(v.e_psel));
      chk({tag, " paddr"}, paddr_seen, v.adr);
      chk({tag, " pstrb"}, 32'(pstrb_seen), 32'(v.e_pstrb));
      chk({tag, " pwrite"}, 32'(pwrite_seen), 32'(v.we));
      if (v.we) chk({tag, " pwdata"}, pwdata_seen, v.wdata);
    end else begin
      chk({tag, " no psel"}, 32'(any_psel), 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, " ack/err one cycle"}, 32'({ack, err}), 32'd0);
    chk({tag, " dat_o cleared"}, dat_o, 32'h0);
    if (!done) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  initial begin
    logic saw_resp, saw_pen;
    vec_t v;
    int   r;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    for (int k = 0; k < NS; k++) begin
      slv_wait[k] = 0; slv_err[k] = 1'b0; slv_data[k] = 32'h0;
    end

    //          we    adr           wdata         sel   wt   serr  rdata         ack   err  lat  dat           psel    pstrb
    tbl[0] = '{1'b1, 32'h0000_2010, 32'hA5A5_1234, 4'hF, 0,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 3, 32'h0000_0000, 3'b100, 4'hF};
    tbl[1] = '{1'b0, 32'h0000_1004, 32'h1111_2222, 4'hF, 5,   1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 8, 32'hCAFE_F00D, 3'b010, 4'h0};
    tbl[2] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 0,   1'b1, 32'h1234_5678, 1'b0, 1'b1, 3, 32'h0000_0000, 3'b001, 4'h0};
    tbl[3] = '{1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 0,   1'b0, 32'h0000_0000, 1'b0, 1'b1, 2, 32'h0000_0000, 3'b000, 4'hF};
    tbl[4] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 4'hF, 100, 1'b0, 32'h7777_7777, 1'b0, 1'b1, 18, 32'h0000_0000, 3'b100, 4'h0};
    tbl[5] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 2,   1'b0, 32'h55AA_0FF0, 1'b1, 1'b0, 5, 32'h55AA_0FF0, 3'b001, 4'h0};
    tbl[6] = '{1'b1, 32'h0000_1ABC, 32'h0102_0304, 4'h3, 3,   1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 6, 32'h0000_0000, 3'b010, 4'h3};
    tbl[7] = '{1'b0, 32'h0000_2FFC, 32'h0000_0000, 4'hF, 15,  1'b0, 32'h0BAD_BEEF, 1'b1, 1'b0, 18, 32'h0BAD_BEEF, 3'b100, 4'h0};
    tbl[8] = '{1'b1, 32'hFFFF_C004, 32'h89AB_CDEF, 4'h5, 1,   1'b0, 32'h0000_0000, 1'b1, 1'b0, 4, 32'h0000_0000, 3'b001, 4'h5};
    tbl[9] = '{1'b0, 32'h8000_F000, 32'h0000_0000, 4'hF, 0,   1'b0, 32'h0000_0000, 1'b0, 1'b1, 2, 32'h0000_0000, 3'b000, 4'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack/err", 32'({ack, err}), 32'd0);
    chk("reset dat_o", dat_o, 32'h0);
    chk("reset psel/penable/pwrite", 32'({psel, penable, pwrite}), 32'd0);
    chk("reset paddr", paddr, 32'h0);
    chk("reset pwdata", pwdata, 32'h0);
    chk("reset pstrb", 32'(pstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Abort: cyc dropped during SETUP; APB completes, no ack/err.
    slv_wait[1] = 3; slv_err[1] = 1'b0; slv_data[1] = 32'h1357_9BDF;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0000_1000; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    saw_resp = 1'b0; saw_pen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack || err) saw_resp = 1'b1;
      if (penable) saw_pen = 1'b1;
    end
    chk("abort no ack/err", 32'(saw_resp), 32'd0);
    chk("abort access ran", 32'(saw_pen), 32'd1);
    chk("abort bus idle", 32'({psel, penable}), 32'd0);
    apply(tbl[0], "after abort");

    // Reset during an ACCESS wait state.
    slv_wait[2] = 10; slv_err[2] = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h0000_2000; wdat = 32'hFACE_0001; sel = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset in access", 32'({psel, penable}), 32'({3'b100, 1'b1}));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset ack/err", 32'({ack, err}), 32'd0);
    chk("mid reset psel/penable/pwrite", 32'({psel, penable, pwrite}), 32'd0);
    chk("mid reset paddr", paddr, 32'h0);
    chk("mid reset pwdata", pwdata, 32'h0);
    chk("mid reset pstrb/dat_o", 32'(pstrb) | dat_o, 32'h0);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    saw_resp = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack || err) saw_resp = 1'b1;
    end
    chk("post reset no ack/err", 32'(saw_resp), 32'd0);
    apply(tbl[0], "after reset");

    // Randomized transfers against the reference model.
    for (int i = 0; i < 30; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.adr   = $urandom;
      v.wdata = $urandom;
      v.sel   = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 6)       v.wt = r;
      else if (r == 6) v.wt = T - 1;
      else if (r == 7) v.wt = T;
      else if (r == 8) v.wt = T + int'($urandom_range(0, 10));
      else             v.wt = int'($urandom_range(0, 3));
      v.serr  = ($urandom_range(0, 3) == 0);
      v.rdata = $urandom;
      v = model(v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
